// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master that copies a block of words, one read then one write per word.
// Define ONCHIP_MEM_COPY_FILL_EN to add a pattern-fill mode (fill_mode/fill_pattern ports).
module onchip_mem_copy_master #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
`ifdef ONCHIP_MEM_COPY_FILL_EN
  input  logic                fill_mode,
  input  logic [DATA_W-1:0]   fill_pattern,
`endif
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   src_ptr, dst_ptr;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    words_inc;
  logic [DATA_W-1:0]   data_q;
  logic                fill_q;
  logic                fill_start;
  logic [DATA_W-1:0]   start_data;

`ifdef ONCHIP_MEM_COPY_FILL_EN
  assign fill_start = fill_mode;
  assign start_data = fill_pattern;
`else
  assign fill_start = 1'b0;
  assign start_data = '0;
`endif

  assign words_inc = words_done + 1'b1;

  // Bus outputs decode straight from registered state so a reset drops requests at once.
  assign avm_read       = (state == S_RD_REQ);
  assign avm_write      = (state == S_WR_REQ);
  assign avm_address    = (state == S_WR_REQ) ? dst_ptr : src_ptr;
  assign avm_writedata  = data_q;
  assign avm_byteenable = '1;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0)    state_n = S_DONE;
          else if (fill_start) state_n = S_WR_REQ;
          else                 state_n = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) state_n = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
          if (words_inc == len_q) state_n = S_DONE;
          else if (fill_q)        state_n = S_WR_REQ;
          else                    state_n = S_RD_REQ;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      len_q      <= '0;
      words_done <= '0;
      data_q     <= '0;
      fill_q     <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RD_REQ) || (state_n == S_RD_WAIT) || (state_n == S_WR_REQ);
      done  <= (state_n == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            len_q      <= length;
            words_done <= '0;
            fill_q     <= fill_start;
            data_q     <= start_data;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) data_q <= avm_readdata;
        end
        S_WR_REQ: begin
          if (!avm_waitrequest) begin
            src_ptr    <= src_ptr + 1'b1;
            dst_ptr    <= dst_ptr + 1'b1;
            words_done <= words_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Randomized bench for onchip_mem_copy_master: Avalon slave memory model plus a
// sequential-copy reference model; honours ONCHIP_MEM_COPY_FILL_EN when defined.
module tb_onchip_mem_copy_master;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
`ifdef ONCHIP_MEM_COPY_FILL_EN
  logic              fill_mode = 1'b0;
  logic [DATA_W-1:0] fill_pattern = '0;
`endif
  logic              busy, done;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              avm_waitrequest = 1'b0;

  onchip_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef ONCHIP_MEM_COPY_FILL_EN
    .fill_mode(fill_mode), .fill_pattern(fill_pattern),
`endif
    .busy(busy), .done(done), .words_done(words_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents; unwritten words read as a recognisable address-tagged value.
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : {16'hC0DE, a};
  endfunction

  // Slave/monitor state
  bit          stress = 0;
  int          lat_max = 1;
  int          rd_pend = 0;
  logic [31:0] rd_data;
  bit          stall_prev = 0;
  logic [63:0] snap;
  logic [15:0] read_addrs [$];
  int n_reads, n_writes, done_cnt, done_cyc, first_rd_cyc, busy_seen, req_cycles;
  int streak, max_streak;

  task automatic clear_mon();
    read_addrs.delete();
    n_reads = 0; n_writes = 0; done_cnt = 0; done_cyc = -1; first_rd_cyc = -1;
    busy_seen = 0; req_cycles = 0; streak = 0; max_streak = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Avalon slave: acts on each falling edge, so the rising edge samples stable values.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_pend = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        stall_prev = 0;
      end else begin
        if (stall_prev)
          check("stall_hold", {14'd0, avm_read, avm_write, avm_address, avm_writedata}, snap);
        avm_readdatavalid = 1'b0;
        if (rd_pend > 0) begin
          rd_pend--;
          if (rd_pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = rd_data;
          end
        end else if (stress && $urandom_range(0, 4) == 0) begin
          avm_readdatavalid = 1'b1;  // stray valid with no read pending
          avm_readdata = $urandom;
        end
        avm_waitrequest = stress ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_read || avm_write) begin
          req_cycles++;
          check("rd_wr_exclusive", {63'd0, avm_read & avm_write}, 64'd0);
        end
        if (avm_read && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (avm_read && !avm_waitrequest) begin
          check("one_outstanding", {63'd0, rd_pend != 0}, 64'd0);
          read_addrs.push_back(avm_address);
          rd_data = mem_rd(avm_address);
          rd_pend = stress ? int'($urandom_range(1, lat_max)) : 1;
          n_reads++;
        end
        if (avm_write) begin
          streak++;
          if (streak > max_streak) max_streak = streak;
          if (!avm_waitrequest) begin
            mem[int'(avm_address)] = avm_writedata;
            n_writes++;
          end
        end else begin
          streak = 0;
        end
        stall_prev = (avm_read || avm_write) && avm_waitrequest;
        snap = {14'd0, avm_read, avm_write, avm_address, avm_writedata};
        if (busy) busy_seen = 1;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_low_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                         input bit str, input int lmax, input bit inject,
                         input bit fill, input logic [31:0] pat, output int t_start);
    logic [31:0] ref_mem [int];
    int sa, da;
    bit got_done;
    ref_mem = mem;
    for (int i = 0; i < int'(n); i++) begin
      sa = (int'(s) + i) & 'hFFFF;
      da = (int'(d) + i) & 'hFFFF;
      if (fill) ref_mem[da] = pat;
      else      ref_mem[da] = ref_mem.exists(sa) ? ref_mem[sa] : {16'hC0DE, sa[15:0]};
    end
    step();
    clear_mon();
    stress = str;
    lat_max = lmax;
    src_addr = s; dst_addr = d; length = n;
`ifdef ONCHIP_MEM_COPY_FILL_EN
    fill_mode = fill; fill_pattern = pat;
`endif
    start = 1'b1;
    t_start = cyc;
    step();
    start = 1'b0;
    got_done = 0;
    for (int k = 0; k < 5000 && !got_done; k++) begin
      if (done_cnt > 0) got_done = 1;
      else begin
        if (inject && k == 4) begin
          start = 1'b1;
          src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 16'($urandom_range(1, 9));
        end
        if (inject && k == 5) start = 1'b0;
        step();
      end
    end
    check("done_seen", {63'd0, got_done}, 64'd1);
    check("words_done", 64'(words_done), 64'(n));
    if (inject) begin
      start = 1'b1;  // lands while the FSM sits in DONE
      src_addr = 16'h7777; length = 16'd5;
    end
    step();
    start = 1'b0;
    step();
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_after_done", {63'd0, busy}, 64'd0);
    check("n_reads", 64'(n_reads), fill ? 64'd0 : 64'(n));
    check("n_writes", 64'(n_writes), 64'(n));
    if (!fill)
      for (int i = 0; i < int'(n) && i < read_addrs.size(); i++)
        check("rd_addr", 64'(read_addrs[i]), 64'((int'(s) + i) & 'hFFFF));
    for (int i = 0; i < int'(n); i++) begin
      da = (int'(d) + i) & 'hFFFF;
      check("dst_data", 64'(mem_rd(16'(da))), 64'(ref_mem[da]));
    end
    stress = 0;
  endtask

  initial begin
    int t0;
    bit found;
    logic [15:0] rs, rdst, rn;

    reset_n = 1'b0;
    repeat (3) step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_words_done", 64'(words_done), 64'd0);
    check("rst_read", {63'd0, avm_read}, 64'd0);
    check("rst_write", {63'd0, avm_write}, 64'd0);
    check("rst_address", 64'(avm_address), 64'd0);
    check("rst_writedata", 64'(avm_writedata), 64'd0);
    check("rst_byteenable", 64'(avm_byteenable), 64'hF);
    reset_n = 1'b1;
    step();

    // Basic copy with fixed data
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'hA0 + i;
    run_job(16'h0010, 16'h0100, 16'd4, 0, 1, 0, 0, '0, t0);
    check("basic_latency", 64'(done_cyc - first_rd_cyc), 64'd12);
    for (int i = 0; i < 4; i++)
      check("basic_dst", 64'(mem_rd(16'h0100 + 16'(i))), 64'(32'hA0 + i));

    // Waitrequest / latency stress
    for (int i = 0; i < 16; i++) mem[16'h1000 + i] = $urandom;
    run_job(16'h1000, 16'h2000, 16'd16, 1, 5, 0, 0, '0, t0);

    // Zero length
    run_job(16'h0050, 16'h0060, 16'd0, 0, 1, 0, 0, '0, t0);
    check("zero_no_requests", 64'(req_cycles), 64'd0);
    check("zero_done_latency", 64'(done_cyc - t0), 64'd1);
    check("zero_busy_never", 64'(busy_seen), 64'd0);

    // Address wrap with ignored starts mid-job and in DONE
    run_job(16'hFFFE, 16'h0200, 16'd3, 0, 1, 1, 0, '0, t0);

    // Reset during the second word's write
    step();
    clear_mon();
    src_addr = 16'h0300; dst_addr = 16'h0400; length = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (avm_write && words_done == 16'd1) found = 1;
      else step();
    end
    check("reset_point_found", {63'd0, found}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_write", {63'd0, avm_write}, 64'd0);
    check("abort_read", {63'd0, avm_read}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_words_done", 64'(words_done), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_job(16'h0300, 16'h0500, 16'd4, 0, 1, 0, 0, '0, t0);

    // Random jobs under stress
    repeat (6) begin
      rs = 16'($urandom); rdst = 16'($urandom); rn = 16'($urandom_range(1, 24));
      run_job(rs, rdst, rn, 1, int'($urandom_range(1, 5)), 0, 0, '0, t0);
    end

    // Overlap with dst above src: data propagates forward
    for (int i = 0; i < 2; i++) mem[16'h3000 + i] = $urandom;
    run_job(16'h3000, 16'h3002, 16'd10, 1, 3, 0, 0, '0, t0);

`ifdef ONCHIP_MEM_COPY_FILL_EN
    run_job(16'h0000, 16'h0040, 16'd8, 0, 1, 0, 1, 32'hDEADBEEF, t0);
    check("fill_streak", 64'(max_streak), 64'd8);
    for (int i = 0; i < 8; i++)
      check("fill_dst", 64'(mem_rd(16'h0040 + 16'(i))), 64'h0000_0000_DEAD_BEEF);
    fill_mode = 1'b0;
    run_job(16'h0010, 16'h0180, 16'd4, 0, 1, 0, 0, '0, t0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
